// File: rtl/irq_dispatch.sv
// Sequential wrapper around the 27-channel priority encoder: captures source events, runs the CPU
// irq/ack/eoi handshake. Define IRQ_LEVEL_EN for level-sensitive sources (default: rising-edge capture).
module irq_dispatch #(
    parameter int NCH     = 9,
    parameter int VEC_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*NCH-1:0]     irq_src,
    input  logic                 mask_wr,
    input  logic [NCH-1:0]       mask_data,
    output logic [NCH-1:0]       req_a,
    output logic [NCH-1:0]       req_b,
    output logic [NCH-1:0]       req_c,
    output logic [NCH-1:0]       req_en,
    input  logic                 grant_a,
    input  logic                 grant_b,
    input  logic                 grant_c,
    input  logic [3:0]           grant_chan,
    output logic                 cpu_irq,
    output logic [VEC_W-1:0]     cpu_vec,
    input  logic                 cpu_ack,
    input  logic                 cpu_eoi,
    output logic                 busy,
    output logic                 err
);

    localparam int NSRC  = 3 * NCH;
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ASSERT,
        ST_SERVICE
    } state_t;

    state_t              state_q, state_d;
    logic [NSRC-1:0]     src_q, src_d;
    logic [NSRC-1:0]     pending_q, pending_d;
    logic [NCH-1:0]      en_q, en_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                err_q, err_d;
    logic                clr_fire;

    // Grant decode: exactly one bus and an in-range channel is a valid grant.
    logic [1:0]          grant_cnt;
    logic [1:0]          grant_bus;
    logic                grant_none;
    logic                grant_valid;
    logic                grant_bad;
    logic [VEC_W-1:0]    grant_vec;

    assign grant_cnt   = {1'b0, grant_a} + {1'b0, grant_b} + {1'b0, grant_c};
    assign grant_none  = (grant_cnt == 2'd0);
    assign grant_valid = (grant_cnt == 2'd1) && (grant_chan <= 4'(NCH - 1));
    assign grant_bad   = !grant_none && !grant_valid;

    always_comb begin
        grant_bus = 2'd0;
        if (grant_b) begin
            grant_bus = 2'd1;
        end else if (grant_c) begin
            grant_bus = 2'd2;
        end
    end

    assign grant_vec = VEC_W'(grant_bus) * VEC_W'(NCH) + VEC_W'(grant_chan);

    assign src_d = irq_src;
    assign en_d  = mask_wr ? mask_data : en_q;

    // The vector equals the flat source index, so vec_q also names the bit to clear on ack.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
`ifdef IRQ_LEVEL_EN
            assign pending_d[gi] = irq_src[gi];
`else
            logic set_bit;
            logic clr_bit;
            assign set_bit       = irq_src[gi] & ~src_q[gi];
            assign clr_bit       = clr_fire && (vec_q == VEC_W'(gi));
            assign pending_d[gi] = set_bit | (pending_q[gi] & ~clr_bit);
`endif
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        timer_d  = timer_q;
        err_d    = err_q;
        clr_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (grant_valid) begin
                    vec_d   = grant_vec;
                    timer_d = '0;
                    state_d = ST_ASSERT;
                end else begin
                    if (grant_bad) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // Ack takes priority over an expiring timer.
                if (cpu_ack) begin
                    clr_fire = 1'b1;
                    state_d  = ST_SERVICE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SERVICE: begin
                if (cpu_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            pending_q <= '0;
            en_q      <= '1;
            vec_q     <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            vec_q     <= vec_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
        end
    end

    assign req_a   = pending_q[NCH-1:0];
    assign req_b   = pending_q[2*NCH-1:NCH];
    assign req_c   = pending_q[3*NCH-1:2*NCH];
    assign req_en  = en_q;
    assign cpu_irq = (state_q == ST_ASSERT);
    assign cpu_vec = vec_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch: behavioural priority encoder (A>B>C, lowest channel first), vector table,
// hand-written handshake sequences and randomized bursts drained in ascending vector order.
module tb_irq_dispatch;

    logic        clk;
    logic        rst;
    logic [26:0] irq_src;
    logic        mask_wr;
    logic [8:0]  mask_data;
    logic [8:0]  req_a, req_b, req_c, req_en;
    logic        grant_a, grant_b, grant_c;
    logic [3:0]  grant_chan;
    logic        cpu_irq;
    logic [4:0]  cpu_vec;
    logic        cpu_ack, cpu_eoi;
    logic        busy, err;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;

    irq_dispatch dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .mask_wr(mask_wr), .mask_data(mask_data),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_en(req_en),
        .grant_a(grant_a), .grant_b(grant_b), .grant_c(grant_c), .grant_chan(grant_chan),
        .cpu_irq(cpu_irq), .cpu_vec(cpu_vec), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] lowest(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 8; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Encoder model; fault_mode injects a double grant (1) or an out-of-range channel (2).
    always_comb begin
        grant_a = 1'b0; grant_b = 1'b0; grant_c = 1'b0; grant_chan = 4'd0;
        if ((req_a & req_en) != 9'd0) begin
            grant_a = 1'b1; grant_chan = lowest(req_a & req_en);
        end else if ((req_b & req_en) != 9'd0) begin
            grant_b = 1'b1; grant_chan = lowest(req_b & req_en);
        end else if ((req_c & req_en) != 9'd0) begin
            grant_c = 1'b1; grant_chan = lowest(req_c & req_en);
        end
        if (fault_mode == 1) begin
            grant_a = 1'b1; grant_c = 1'b1;
        end else if (fault_mode == 2) begin
            grant_a = 1'b1; grant_b = 1'b0; grant_c = 1'b0; grant_chan = 4'd9;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic set_mask(input logic [8:0] v);
        mask_wr = 1'b1; mask_data = v; tick(); mask_wr = 1'b0;
    endtask

    task automatic pulse(input logic [26:0] m);
        irq_src = m; tick(); irq_src = '0;
    endtask

    task automatic do_ack();
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    endtask

    task automatic do_eoi();
        cpu_eoi = 1'b1; tick(); cpu_eoi = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (cpu_irq !== 1'b1 && n < 60) begin
            tick(); n++;
        end
        check({tag, "_irq_wait"}, 32'(cpu_irq), 32'd1);
    endtask

    // Serve every enabled bit of 'bits' in ascending vector order, clearing it from 'left'.
    task automatic serve_all(input logic [26:0] bits, input logic [8:0] en, inout logic [26:0] left);
        for (int i = 0; i < 27; i++) begin
            if (bits[i] && en[i % 9]) begin
                wait_irq("rnd");
                check("rnd_vec", 32'(cpu_vec), 32'(i));
                left[i] = 1'b0;
                repeat ($urandom_range(0, 4)) tick();
                do_ack();
                repeat ($urandom_range(0, 3)) tick();
                do_eoi();
            end
        end
    endtask

    typedef struct packed {
        logic [26:0] src;
        logic [8:0]  en;
        logic        exp_irq;
        logic [4:0]  exp_vec;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [26:0] src;
        logic [26:0] left;
        logic [8:0]  en;

        rst = 1'b1; irq_src = '0; mask_wr = 1'b0; mask_data = '0;
        cpu_ack = 1'b0; cpu_eoi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_irq", 32'(cpu_irq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req_en", 32'(req_en), 32'h1FF);
        check("rst_req", 32'({req_c, req_b, req_a}), 32'd0);
        check("rst_vec", 32'(cpu_vec), 32'd0);

`ifdef IRQ_LEVEL_EN
        // Held source keeps re-serving until it is deasserted.
        irq_src = 27'(1) << 7;
        tick(); tick(); tick();
        check("lvl_irq", 32'(cpu_irq), 32'd1);
        check("lvl_vec", 32'(cpu_vec), 32'd7);
        do_ack();
        check("lvl_pend_held", 32'(req_a[7]), 32'd1);
        do_eoi();
        wait_irq("lvl_again");
        check("lvl_vec2", 32'(cpu_vec), 32'd7);
        do_ack();
        irq_src = '0;
        tick();
        check("lvl_pend_clear", 32'(req_a), 32'd0);
        do_eoi();
        seen = 1'b0;
        repeat (6) begin tick(); seen |= cpu_irq; end
        check("lvl_no_reserve", 32'(seen), 32'd0);
        check("lvl_idle", 32'(busy), 32'd0);
        $display("level-mode sequence done");
`else
        tbl[0] = '{27'h0001000, 9'h1FF, 1'b1, 5'd12};
        tbl[1] = '{27'h0100004, 9'h1FF, 1'b1, 5'd2};
        tbl[2] = '{27'h4000000, 9'h1FF, 1'b1, 5'd26};
        tbl[3] = '{27'h0000001, 9'h1FF, 1'b1, 5'd0};
        tbl[4] = '{27'h0000220, 9'h1DF, 1'b1, 5'd9};
        tbl[5] = '{27'h2020000, 9'h1FF, 1'b1, 5'd17};
        tbl[6] = '{27'h0000008, 9'h000, 1'b0, 5'd0};
        tbl[7] = '{27'h0040100, 9'h0FF, 1'b1, 5'd18};

        for (int t = 0; t < 8; t++) begin
            hard_reset();
            set_mask(tbl[t].en);
            pulse(tbl[t].src);
            tick();
            check("tbl_not_early", 32'(cpu_irq), 32'd0);
            tick();
            check("tbl_irq", 32'(cpu_irq), 32'(tbl[t].exp_irq));
            if (tbl[t].exp_irq) check("tbl_vec", 32'(cpu_vec), 32'(tbl[t].exp_vec));
            $display("table %0d: src=%07h en=%03h irq=%0d vec=%0d", t, tbl[t].src, tbl[t].en, cpu_irq, cpu_vec);
        end

        // Single source through the full handshake, including ignored ack/eoi.
        hard_reset();
        pulse(27'(1) << 12);
        tick(); tick();
        check("hs_irq", 32'(cpu_irq), 32'd1);
        check("hs_vec", 32'(cpu_vec), 32'd12);
        do_eoi();
        check("hs_eoi_ignored", 32'(cpu_irq), 32'd1);
        do_ack();
        check("hs_ack_irq_low", 32'(cpu_irq), 32'd0);
        check("hs_ack_clear", 32'(req_b), 32'd0);
        check("hs_vec_held", 32'(cpu_vec), 32'd12);
        do_ack();
        check("hs_ack_ignored_busy", 32'(busy), 32'd1);
        do_eoi();
        check("hs_eoi_idle", 32'(busy), 32'd0);
        $display("handshake sequence done");

        // Simultaneous A and C sources: A first, then C.
        pulse((27'(1) << 20) | (27'(1) << 2));
        wait_irq("pair1");
        check("pair_first", 32'(cpu_vec), 32'd2);
        do_ack(); do_eoi();
        wait_irq("pair2");
        check("pair_second", 32'(cpu_vec), 32'd20);
        do_ack(); do_eoi();
        $display("priority pair sequence done");

        // Timeout: irq held TIMEOUT cycles, then re-arbitrated with the same vector.
        hard_reset();
        pulse(27'(1) << 12);
        wait_irq("to");
        begin
            int n;
            n = 0;
            while (cpu_irq === 1'b1 && n < 40) begin tick(); n++; end
            check("to_high_cycles", 32'(n), 32'd15);
        end
        check("to_pending_kept", 32'(req_b), 32'h008);
        tick();
        check("to_settle_low", 32'(cpu_irq), 32'd0);
        tick();
        check("to_reassert", 32'(cpu_irq), 32'd1);
        check("to_same_vec", 32'(cpu_vec), 32'd12);
        do_ack(); do_eoi();
        $display("timeout sequence done");

        // New edge on the served source in the ack cycle: set wins, re-served after eoi.
        hard_reset();
        pulse(27'(1) << 12);
        wait_irq("re");
        irq_src = 27'(1) << 12; cpu_ack = 1'b1;
        tick();
        irq_src = '0; cpu_ack = 1'b0;
        check("re_irq_low", 32'(cpu_irq), 32'd0);
        check("re_still_pending", 32'(req_b), 32'h008);
        do_eoi();
        wait_irq("re2");
        check("re_vec", 32'(cpu_vec), 32'd12);
        do_ack();
        check("re_cleared", 32'(req_b), 32'd0);
        do_eoi();
        $display("re-edge sequence done");

        // Double grant sets sticky err and never raises irq.
        hard_reset();
        fault_mode = 1;
        pulse(27'(1) << 4);
        seen = 1'b0;
        repeat (6) begin tick(); seen |= cpu_irq; end
        check("dbl_err", 32'(err), 32'd1);
        check("dbl_no_irq", 32'(seen), 32'd0);
        fault_mode = 0;
        wait_irq("dbl_recover");
        check("dbl_vec", 32'(cpu_vec), 32'd4);
        check("dbl_err_sticky", 32'(err), 32'd1);
        do_ack(); do_eoi();

        // Out-of-range channel also flags err; then reset mid-ASSERT clears everything.
        hard_reset();
        check("oor_err_cleared", 32'(err), 32'd0);
        fault_mode = 2;
        pulse(27'(1) << 0);
        repeat (4) tick();
        check("oor_err", 32'(err), 32'd1);
        fault_mode = 0;
        set_mask(9'h0FF);
        pulse(27'(1) << 12);
        wait_irq("mid");
        rst = 1'b1; cpu_ack = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_irq", 32'(cpu_irq), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pend", 32'({req_c, req_b, req_a}), 32'd0);
        check("mid_rst_en", 32'(req_en), 32'h1FF);
        check("mid_rst_err", 32'(err), 32'd0);
        $display("error and reset sequence done");

        // All channels masked: no irq and no err, served once enabled.
        set_mask(9'h000);
        pulse(27'(1) << 4);
        seen = 1'b0;
        repeat (10) begin tick(); seen |= cpu_irq; end
        check("msk_no_irq", 32'(seen), 32'd0);
        check("msk_no_err", 32'(err), 32'd0);
        check("msk_pending", 32'(req_a), 32'h010);
        set_mask(9'h1FF);
        wait_irq("msk");
        check("msk_vec", 32'(cpu_vec), 32'd4);
        do_ack(); do_eoi();
        $display("mask sequence done");

        // Randomized bursts: enabled bits drain in ascending order, masked bits stay pending.
        for (int r = 0; r < 16; r++) begin
            hard_reset();
            src = 27'($urandom);
            if (src == 27'd0) src = 27'd1;
            en = (r % 3 == 0) ? 9'h1FF : 9'($urandom);
            set_mask(en);
            pulse(src);
            left = src;
            serve_all(src, en, left);
            repeat (6) tick();
            check("rnd_quiet", 32'(cpu_irq), 32'd0);
            check("rnd_leftover", 32'({req_c, req_b, req_a}), 32'(left));
            set_mask(9'h1FF);
            serve_all(left, 9'h1FF, left);
            repeat (4) tick();
            check("rnd_idle", 32'(busy), 32'd0);
            check("rnd_err", 32'(err), 32'd0);
            $display("random %0d: src=%07h en=%03h", r, src, en);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
